// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a framed byte stream (length, payload,
// XOR checksum), packs little-endian words into the memory write port and stalls the core meanwhile.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | no load since reset; core runs
// S_LEN_LO | waiting for length byte [7:0]
// S_LEN_HI | waiting for length byte [15:8]; range-checks the length
// S_DATA   | receiving payload bytes, one word write per 4 bytes
// S_CSUM   | waiting for checksum byte
// S_DONE   | image loaded and verified; core released
// S_ERROR  | oversize length or checksum mismatch; core held
module imem_loader #(
   parameter int MEM_BYTES  = 1024,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic                  cpu_stall,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [31:0] MAX_LEN = MEM_BYTES;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  len_lo;
   logic [15:0] remain;
   logic [15:0] count;
   logic [7:0]  csum;
   logic [31:0] word_buf;

   logic        xfer;
   logic [15:0] len_full;
   logic        len_zero;
   logic        len_too_big;
   logic        last_byte;
   logic [1:0]  lane;
   logic [31:0] word_nxt;

   assign in_ready  = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA)   || (state == S_CSUM);
   assign cpu_stall = in_ready || (state == S_ERROR);
   assign done      = (state == S_DONE);
   assign error     = (state == S_ERROR);

   assign xfer        = in_valid && in_ready;
   assign len_full    = {in_data, len_lo};
   assign len_zero    = (len_full == 16'd0);
   assign len_too_big = ({16'd0, len_full} > MAX_LEN);
   // remain is a down-counter loaded with the length; terminal count 1 marks the final byte
   assign last_byte   = (remain == 16'd1);
   assign lane        = count[1:0];
   assign word_nxt    = word_buf | ({24'd0, in_data} << {lane, 3'b000});

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (xfer) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (xfer) begin
               if (len_zero)         state_nxt = S_CSUM;
               else if (len_too_big) state_nxt = S_ERROR;
               else                  state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (xfer && last_byte) state_nxt = S_CSUM;
         end
         S_CSUM: begin
            if (xfer) state_nxt = (in_data == csum) ? S_DONE : S_ERROR;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_lo   <= 8'd0;
         remain   <= 16'd0;
         count    <= 16'd0;
         csum     <= 8'd0;
         word_buf <= 32'd0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= 32'd0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  count    <= 16'd0;
                  csum     <= 8'd0;
                  word_buf <= 32'd0;
               end
            end
            S_LEN_LO: begin
               if (xfer) len_lo <= in_data;
            end
            S_LEN_HI: begin
               if (xfer) remain <= len_full;
            end
            S_DATA: begin
               if (xfer) begin
                  csum   <= csum ^ in_data;
                  count  <= count + 16'd1;
                  remain <= remain - 16'd1;
                  // Emitting clears the buffer, so a short final word is zero-padded
                  if (lane == 2'd3 || last_byte) begin
                     wr_en    <= 1'b1;
                     wr_addr  <= ADDR_WIDTH'({count[15:2], 2'b00});
                     wr_data  <= word_nxt;
                     word_buf <= 32'd0;
                  end else begin
                     word_buf <= word_nxt;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected word writes are queued as frames are
// driven and popped by a write monitor; status outputs are checked inline per scenario.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        cpu_stall;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_fail   = 0;
   int wr_count = 0;
   int cyc      = 0;

   logic [63:0] exp_q[$];
   logic [7:0]  payload[$];

   imem_loader #(.MEM_BYTES(1024), .ADDR_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cpu_stall (cpu_stall),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      logic [63:0] e;
      if (wr_en) begin
         wr_count++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write addr=%h data=%h (no write expected)", wr_addr, wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e) begin
               n_fail++;
               $display("FAIL write addr=%h data=%h expected addr=%h data=%h",
                        wr_addr, wr_data, e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int gaps  = 0;
      int guard = 0;
      while (rnd && gaps < 3 && $urandom_range(1, 0) == 0) begin
         in_valid = 1'b0;
         tick();
         gaps++;
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL ready_timeout in_ready=%b expected 1", in_ready);
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input bit rnd, input bit bad);
      logic [7:0]  cs;
      logic [31:0] w;
      int          n;
      cs = 8'h00;
      n  = payload.size();
      foreach (payload[i]) cs ^= payload[i];
      for (int i = 0; i < n; i += 4) begin
         w = 32'd0;
         for (int j = 0; j < 4 && i + j < n; j++) w[8*j +: 8] = payload[i+j];
         exp_q.push_back({32'(i), w});
      end
      send_byte(n[7:0], rnd);
      send_byte(n[15:8], rnd);
      foreach (payload[i]) send_byte(payload[i], rnd);
      send_byte(bad ? (cs ^ 8'h01) : cs, rnd);
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (2) tick();
      n_checks++;
      if ({in_ready, wr_en, cpu_stall, done, error} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl rdy/wr/stall/done/err=%b expected 00000",
                  {in_ready, wr_en, cpu_stall, done, error});
      end
      n_checks++;
      if (wr_addr !== 32'd0 || wr_data !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_bus addr=%h data=%h expected 0/0", wr_addr, wr_data);
      end
      rst      = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      tick();
      n_checks++;
      if (cpu_stall !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_start_ignored stall=%b ready=%b expected 0/0", cpu_stall, in_ready);
      end
   endtask

   task automatic test_program();
      int t0;
      payload = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      pulse_start();
      n_checks++;
      if (cpu_stall !== 1'b1 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start_stall stall=%b ready=%b expected 1/1", cpu_stall, in_ready);
      end
      t0 = cyc;
      send_frame(1'b0, 1'b0);
      n_checks++;
      if (done !== 1'b1 || cpu_stall !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL program_done done=%b stall=%b err=%b expected 1/0/0", done, cpu_stall, error);
      end
      n_checks++;
      if (cyc - t0 != 11) begin
         n_fail++;
         $display("FAIL throughput cycles=%0d expected 11", cyc - t0);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL program_writes pending=%0d expected 0", exp_q.size());
      end
   endtask

   task automatic test_partial_word();
      payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      pulse_start();
      send_frame(1'b0, 1'b0);
      n_checks++;
      if (done !== 1'b1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL partial_done done=%b pending=%0d expected 1/0", done, exp_q.size());
      end
   endtask

   task automatic test_bad_csum();
      pulse_start();
      send_frame(1'b0, 1'b1);
      n_checks++;
      if (error !== 1'b1 || done !== 1'b0 || cpu_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL bad_csum err=%b done=%b stall=%b expected 1/0/1", error, done, cpu_stall);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL bad_csum_writes pending=%0d expected 0", exp_q.size());
      end
      pulse_start();
      n_checks++;
      if (error !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL error_restart err=%b ready=%b expected 0/1", error, in_ready);
      end
      payload = '{8'h01, 8'h02, 8'h03, 8'h04};
      send_frame(1'b0, 1'b0);
      n_checks++;
      if (done !== 1'b1 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL recover_done done=%b err=%b expected 1/0", done, error);
      end
   endtask

   task automatic test_len_limits();
      int w0;
      w0 = wr_count;
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h04, 1'b0);
      n_checks++;
      if (error !== 1'b1 || in_ready !== 1'b0 || cpu_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL oversize err=%b ready=%b stall=%b expected 1/0/1", error, in_ready, cpu_stall);
      end
      repeat (3) tick();
      payload = {};
      pulse_start();
      send_frame(1'b0, 1'b0);
      n_checks++;
      if (done !== 1'b1 || wr_count != w0) begin
         n_fail++;
         $display("FAIL zero_len done=%b writes=%0d expected 1/0", done, wr_count - w0);
      end
   endtask

   task automatic test_max_len();
      int w0;
      w0 = wr_count;
      payload = {};
      for (int i = 0; i < 1024; i++) payload.push_back(8'($urandom_range(255, 0)));
      pulse_start();
      send_frame(1'b0, 1'b0);
      n_checks++;
      if (done !== 1'b1 || wr_count - w0 != 256 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL max_len done=%b writes=%0d pending=%0d expected 1/256/0",
                  done, wr_count - w0, exp_q.size());
      end
   endtask

   task automatic test_random_valid();
      int w0;
      w0 = wr_count;
      payload = {};
      for (int i = 0; i < 16; i++) payload.push_back(8'($urandom_range(255, 0)));
      pulse_start();
      send_frame(1'b1, 1'b0);
      n_checks++;
      if (done !== 1'b1 || wr_count - w0 != 4 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL random_valid done=%b writes=%0d pending=%0d expected 1/4/0",
                  done, wr_count - w0, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_load();
      int w0;
      w0 = wr_count;
      exp_q.push_back({32'd0, 32'h44332211});
      pulse_start();
      send_byte(8'd16, 1'b0);
      send_byte(8'd0, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b0 || cpu_stall !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_idle ready=%b stall=%b done=%b err=%b expected 0/0/0/0",
                  in_ready, cpu_stall, done, error);
      end
      repeat (5) tick();
      n_checks++;
      if (wr_count - w0 != 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL mid_reset_writes writes=%0d pending=%0d expected 1/0",
                  wr_count - w0, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_program();
      test_partial_word();
      test_bad_csum();
      test_len_limits();
      test_max_len();
      test_random_valid();
      test_reset_mid_load();
      repeat (3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
